key_filter: RTL
===============

KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 20, number of tick samples a level must stay stable before it is accepted (legal 1..255).
REQ-002 SHALL have parameter LONG_CNT, default 100, number of ticks a debounced press must last before key_long fires (legal 1..1023).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  sample-enable strobe; counters advance only in cycles where tick=1.
REQ-006 SHALL have port btn  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-007 SHALL have port key_level  output  1  debounced button level.
REQ-008 SHALL have port key_press  output  1  one-cycle pulse on an accepted press; feeds the stopwatch pause toggle.
REQ-009 SHALL have port key_release  output  1  one-cycle pulse on an accepted release.
REQ-010 SHALL have port key_long  output  1  one-cycle pulse, at most once per press, when the hold reaches LONG_CNT ticks.

Function
REQ-011 SHALL pass btn through a 2-flop synchronizer; only its output (btn_s) is used internally.
REQ-012 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: btn_s=1 -> PRESS_WAIT with debounce counter cleared; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: btn_s=0 -> IDLE with counter cleared (bounce rejected); else counter increments on tick; a tick with counter = DEBOUNCE_CNT-1 -> HELD.
REQ-015 HELD: btn_s=0 -> RELEASE_WAIT with debounce counter cleared; long counter increments on tick and saturates at LONG_CNT.
REQ-016 RELEASE_WAIT: btn_s=1 -> HELD (bounce rejected; long counter keeps its value, no new key_press); else counter increments on tick; a tick with counter = DEBOUNCE_CNT-1 -> IDLE.
REQ-017 All outputs SHALL be registered; key_press is high for exactly the cycle after the edge that enters HELD from PRESS_WAIT.
REQ-018 key_release SHALL be high for exactly the cycle after the edge that enters IDLE from RELEASE_WAIT.
REQ-019 key_level SHALL be 1 in the same cycle key_press is 1 and SHALL stay 1 until the cycle key_release is 1, inclusive.
REQ-020 key_long SHALL pulse for one cycle in the cycle after the long counter first reaches LONG_CNT; an armed flag blocks repeats until the next entry to IDLE.
REQ-021 Long counter and armed flag SHALL clear on every entry to PRESS_WAIT.
REQ-022 With tick=1 every cycle, press latency SHALL be 2 (sync) + DEBOUNCE_CNT + 1 (output register) cycles from btn rising; release latency is symmetric.
REQ-023 Counter widths SHALL be sized from the parameters with no wrap; the debounce counter never exceeds DEBOUNCE_CNT-1.
REQ-024 If tick=0, the FSM SHALL still react to btn_s changes (bounce aborts) but SHALL NOT advance counters.
REQ-025 key_press, key_release and key_long SHALL never be high in the same cycle, except that key_long may coincide with neither pulse.

Reset
REQ-026 reset=1 at any clock edge SHALL force state IDLE, clear the synchronizer, both counters and the armed flag, and drive all outputs to 0 in the next cycle.
REQ-027 Reset asserted while HELD SHALL NOT produce key_release; after reset, a btn still held SHALL be re-debounced and yield a fresh key_press.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state typedef and the default DEBOUNCE_CNT/LONG_CNT constants.
REQ-029 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, synchronous reset to 0).

Verification
REQ-030 Clean press: DEBOUNCE_CNT=4, tick=1 every cycle, btn 0->1 held 20 cycles -> key_press pulse exactly once, 7 cycles after btn rise; key_level 1.
REQ-031 Bounce reject: btn high for 3 cycles then low, repeated 5 times -> no key_press, key_level stays 0.
REQ-032 Release bounce: held key, btn low 2 cycles then high again -> no key_release, no second key_press; final release -> one key_release.
REQ-033 Long press: DEBOUNCE_CNT=4, LONG_CNT=10, hold 40 cycles -> exactly one key_long, 10 ticks after key_press.
REQ-034 Slow tick: tick every 4th cycle, DEBOUNCE_CNT=4, clean press -> key_press between 2+13 and 2+17+1 cycles after btn rise; bounce with tick=0 still aborts.
REQ-035 Reset mid-hold: assert reset 1 cycle while HELD, btn still 1 -> outputs 0, no key_release, new key_press 7 cycles after reset deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the push-button filter.
//   key_state_t          - debounce FSM state encoding
//   DEBOUNCE_CNT_DEF     - default number of stable tick samples to accept a level
//   LONG_CNT_DEF         - default number of held ticks before a long-press pulse
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEBOUNCE_CNT_DEF = 20;
    localparam int LONG_CNT_DEF     = 100;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk   - destination clock
//   reset - synchronous active-high reset, clears both flops to 0
//   d     - asynchronous input level
//   q     - synchronized level, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_filter.sv
// key_filter: debounces a raw push-button and produces press/release/long-press
// events. Counters only advance on tick strobes; bounces abort on any cycle.
//   clk         - system clock, rising edge
//   reset       - synchronous active-high reset
//   tick        - sample-enable strobe for the debounce and long counters
//   btn         - raw asynchronous button level, 1 = pressed
//   key_level   - debounced level
//   key_press   - one-cycle pulse on an accepted press
//   key_release - one-cycle pulse on an accepted release
//   key_long    - one-cycle pulse, once per press, after LONG_CNT held ticks
//   state_dbg   - current FSM state, for observation only
//
// Handshake: there is none; every event output is a registered single-cycle
// pulse with no back-pressure, consumers must sample it on the cycle it is high.
module key_filter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int LONG_CNT     = LONG_CNT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output key_state_t state_dbg
);

    // Debounce counter only needs to reach DEBOUNCE_CNT-1; long counter holds LONG_CNT.
    localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int LW = $clog2(LONG_CNT + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CNT);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);

    logic btn_s;

    key_state_t    state, state_next;
    logic [DW-1:0] deb_cnt, deb_cnt_next;
    logic [LW-1:0] long_cnt, long_cnt_next;
    logic          armed, armed_next;
    logic          level_next, press_next, release_next, long_next;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            long_cnt    <= '0;
            armed       <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_next;
            deb_cnt     <= deb_cnt_next;
            long_cnt    <= long_cnt_next;
            armed       <= armed_next;
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_next;
        end
    end

    always_comb begin
        state_next    = state;
        deb_cnt_next  = deb_cnt;
        long_cnt_next = long_cnt;
        armed_next    = armed;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next    = PRESS_WAIT;
                    deb_cnt_next  = '0;
                    long_cnt_next = '0;
                    armed_next    = 1'b0;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next   = IDLE;
                    deb_cnt_next = '0;
                end else if (tick) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_next   = HELD;
                        deb_cnt_next = '0;
                        press_next   = 1'b1;
                    end else begin
                        deb_cnt_next = deb_cnt + DW'(1);
                    end
                end
            end

            HELD: begin
                if (!btn_s) begin
                    state_next   = RELEASE_WAIT;
                    deb_cnt_next = '0;
                end else if (tick && (long_cnt != LONG_MAX)) begin
                    long_cnt_next = long_cnt + LW'(1);
                    // Fires on the tick that lands the counter on LONG_CNT.
                    if ((long_cnt == LONG_LAST) && !armed) begin
                        long_next  = 1'b1;
                        armed_next = 1'b1;
                    end
                end
            end

            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: back to HELD, long count and armed flag kept.
                    state_next   = HELD;
                    deb_cnt_next = '0;
                end else if (tick) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_next   = IDLE;
                        deb_cnt_next = '0;
                        armed_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        deb_cnt_next = deb_cnt + DW'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Level stays high through the release pulse cycle inclusive.
        level_next = (state_next == HELD) || (state_next == RELEASE_WAIT) || release_next;
    end

    assign state_dbg = state;

endmodule
